key_buffer_ctrl: RTL

// - Sequences the keypoint buffer between the detector (producer) and the matcher (consumer).
// - Generates the buffer's write-strobe (flag) and pop/shift-strobe (hit) and tracks occupancy.
// - Enforces full/empty limits, drains at end of frame and flushes stale keypoints at frame start.
// - Sits between the orientation/descriptor stage and the matcher; buffer data ports bypass it.

---
 rtl/key_buffer_ctrl_if.sv | 28 ++
 rtl/key_buffer_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/key_buffer_ctrl_if.sv
// rtl/key_buffer_ctrl_if.sv - detector/matcher handshake and buffer strobes for key_buffer_ctrl
// master: the surrounding pipeline; slave: the controller.
interface key_buffer_ctrl_if;
  logic kp_valid;
  logic kp_ready;
  logic mt_valid;
  logic mt_req;
  logic buf_flag;
  logic buf_hit;

  modport master (
    output kp_valid,
    output mt_req,
    input  kp_ready,
    input  mt_valid,
    input  buf_flag,
    input  buf_hit
  );

  modport slave (
    input  kp_valid,
    input  mt_req,
    output kp_ready,
    output mt_valid,
    output buf_flag,
    output buf_hit
  );
endinterface

// File: rtl/key_buffer_ctrl.sv
// rtl/key_buffer_ctrl.sv - keypoint buffer sequencer: push/pop strobes, occupancy, drain and flush
// Optional macro KEY_BUFFER_CTRL_DROP_CNT_EN adds o_drop_cnt (rejected-offer counter).
module key_buffer_ctrl #(
  parameter int DEPTH = 100,
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_frame_end,
  key_buffer_ctrl_if.slave bus,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_state,
  output logic             o_done
`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]      o_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_full;
  logic             w_empty;
  logic             w_mt_valid;
  logic             w_kp_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_done;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_mt_valid = ((r_state == COLLECT) || (r_state == DRAIN)) && !w_empty;
  // FLUSH discards stale entries without ever exposing them to the matcher.
  assign w_pop      = (r_state == FLUSH) ? !w_empty : (w_mt_valid && bus.mt_req);
  assign w_kp_ready = (r_state == COLLECT) && (!w_full || w_pop);
  assign w_push     = bus.kp_valid && w_kp_ready;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_frame_start) w_next_state = w_empty ? COLLECT : FLUSH;
      end
      COLLECT: begin
        if (i_frame_start)    w_next_state = (w_count_next == '0) ? COLLECT : FLUSH;
        else if (i_frame_end) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (i_frame_start) begin
          w_next_state = (w_count_next == '0) ? COLLECT : FLUSH;
        end else if (w_count_next == '0) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      FLUSH: begin
        if (w_count_next == '0) w_next_state = COLLECT;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_next;
    end
  end

`ifdef KEY_BUFFER_CTRL_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (i_frame_start) begin
      r_drop_cnt <= '0;
    end else if ((r_state == COLLECT) && bus.kp_valid && !w_kp_ready &&
                 (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_push && !w_pop) |-> !w_full);
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_pop && !w_push) |-> !w_empty);

  assign bus.kp_ready = w_kp_ready;
  assign bus.mt_valid = w_mt_valid;
  assign bus.buf_flag = w_push;
  assign bus.buf_hit  = w_pop;
  assign o_count      = r_count;
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_state      = r_state;
  assign o_done       = w_done;

endmodule
